rgb_cmp_pwm: RTL and testbench

Parametrised magnitude comparator that drives an RGB status LED. It replaces the fixed 2-bit combinational comparator. Operands are captured through a valid/ready handshake, and the greater/equal/less result is registered and held for a minimum display time. The selected LED colour is driven through a programmable PWM brightness stage. The block sits between the switch/input logic and the board RGB LED pins.

---
 rtl/rgb_cmp_pwm.sv | 129 ++++++++++++
 tb/tb_rgb_cmp_pwm.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_cmp_pwm.sv
// Handshaked magnitude comparator that drives an RGB status LED through a PWM brightness stage.
// Define RGB_CMP_SIGNED_EN to compare the operands as two's complement instead of unsigned.
module rgb_cmp_pwm #(
    parameter int WIDTH       = 4,
    parameter int PWM_BITS    = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                valid,
    output logic                ready,
    input  logic [PWM_BITS-1:0] duty,
    output logic                done,
    output logic                gt,
    output logic                eq,
    output logic                lt,
    output logic                red,
    output logic                green,
    output logic                blue,
    output logic [1:0]          dbg_state
);

    // Handshake: a pair is taken on any rising edge where valid && ready;
    // ready depends only on state, and valid while ready is low is dropped.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        HOLD = 2'd2,
        SHOW = 2'd3
    } state_t;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [HW-1:0]       hold_cnt;
    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic                accept;
    logic                cmp_gt;
    logic                cmp_eq;
    logic                cmp_lt;

    assign dbg_state = state;
    assign accept    = valid && ready;
    assign pwm_on    = (pwm_cnt < duty);

`ifdef RGB_CMP_SIGNED_EN
    assign cmp_gt = $signed(a_r) > $signed(b_r);
    assign cmp_lt = $signed(a_r) < $signed(b_r);
`else
    assign cmp_gt = a_r > b_r;
    assign cmp_lt = a_r < b_r;
`endif
    assign cmp_eq = (a_r == b_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE, SHOW: begin
                ready = 1'b1;
                if (valid) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = SHOW;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            hold_cnt <= '0;
            pwm_cnt  <= '0;
            done     <= 1'b0;
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
            red      <= 1'b0;
            green    <= 1'b0;
            blue     <= 1'b0;
        end else begin
            if (accept) begin
                a_r <= a;
                b_r <= b;
            end
            done <= (state == CMP);
            // Flags only change on the CMP->HOLD edge so the display stays stable.
            if (state == CMP) begin
                gt       <= cmp_gt;
                eq       <= cmp_eq;
                lt       <= cmp_lt;
                hold_cnt <= HW'(HOLD_CYCLES - 1);
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            pwm_cnt <= pwm_cnt + 1'b1;
            red     <= gt & pwm_on;
            green   <= eq & pwm_on;
            blue    <= lt & pwm_on;
        end
    end

endmodule

// File: tb/tb_rgb_cmp_pwm.sv
// Directed self-checking bench for rgb_cmp_pwm (WIDTH=4, PWM_BITS=4, HOLD_CYCLES=4).
module tb_rgb_cmp_pwm;

    localparam int WIDTH = 4;
    localparam int PWMB  = 4;
    localparam int HOLDC = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid;
    logic             ready;
    logic [PWMB-1:0]  duty;
    logic             done;
    logic             gt, eq, lt;
    logic             red, green, blue;
    logic [1:0]       dbg_state;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_q[$];

    rgb_cmp_pwm #(.WIDTH(WIDTH), .PWM_BITS(PWMB), .HOLD_CYCLES(HOLDC)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .valid(valid), .ready(ready),
        .duty(duty), .done(done), .gt(gt), .eq(eq), .lt(lt),
        .red(red), .green(green), .blue(blue), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; a = 4'd5; b = 4'd3; duty = '1;
        repeat (3) step();
        rst = 1'b0; valid = 1'b0;
        total++;
        if ({gt, eq, lt, done, red, green, blue} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b need=0000000", {gt, eq, lt, done, red, green, blue});
        end
        total++;
        if (ready !== 1'b1 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_ready got ready=%b state=%0d need ready=1 state=0", ready, dbg_state);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (done !== 1'b0 || {gt, eq, lt} !== 3'b000) begin
                bad++;
                $display("FAIL reset_no_done cycle=%0d got done=%b flags=%b need 0/000", i, done, {gt, eq, lt});
            end
        end
    endtask

    // Accept one pair from a ready state and follow it until ready returns.
    task automatic do_compare(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                              input logic [2:0] exp, input string name);
        int low;
        int guard;
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready_before got=%b need=1", name, ready);
        end
        a = ta; b = tb_v; valid = 1'b1;
        step();
        valid = 1'b0; a = '0; b = '0;
        total++;
        if (ready !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s_k1 got ready=%b done=%b need 0/0", name, ready, done);
        end
        step();
        total++;
        if ({gt, eq, lt} !== exp || done !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_k2 got flags=%b done=%b ready=%b need flags=%b done=1 ready=0",
                     name, {gt, eq, lt}, done, ready, exp);
        end
        low = 2;
        guard = 0;
        step();
        total++;
        if (({red, green, blue} & ~exp) !== 3'b000) begin
            bad++;
            $display("FAIL %s_led got=%b allowed=%b", name, {red, green, blue}, exp);
        end
        while (ready !== 1'b1 && guard < 20) begin
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL %s_done_pulse got done=%b need=0", name, done);
            end
            low++;
            guard++;
            step();
        end
        total++;
        if (low !== HOLDC + 1) begin
            bad++;
            $display("FAIL %s_ready_low got=%0d need=%0d", name, low, HOLDC + 1);
        end
    endtask

    task automatic test_exhaustive();
        logic [2:0] exp;
        duty = '1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                exp = (i > j) ? 3'b100 : ((i == j) ? 3'b010 : 3'b001);
                do_compare(WIDTH'(i), WIDTH'(j), exp, "exh");
            end
        end
    endtask

    task automatic test_handshake();
        int accepts;
        int last_acc;
        int guard;
        logic [2:0] got;
        logic [2:0] want;
        accepts  = 0;
        last_acc = -1;
        exp_q.delete();
        for (int i = 0; i < 24; i++) begin
            if (done === 1'b1) begin
                got = {gt, eq, lt};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL hs_unexpected_done cycle=%0d flags=%b", i, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL hs_flags cycle=%0d got=%b need=%b", i, got, want);
                    end
                end
            end
            a = WIDTH'(i % 8);
            b = WIDTH'((i * 3) % 8);
            valid = 1'b1;
            if (ready === 1'b1) begin
                want = ((i % 8) > ((i * 3) % 8)) ? 3'b100 :
                       (((i % 8) == ((i * 3) % 8)) ? 3'b010 : 3'b001);
                exp_q.push_back(want);
                if (last_acc >= 0) begin
                    total++;
                    if (i - last_acc != HOLDC + 2) begin
                        bad++;
                        $display("FAIL hs_cadence got gap=%0d need=%0d", i - last_acc, HOLDC + 2);
                    end
                end
                last_acc = i;
                accepts++;
            end
            step();
        end
        valid = 1'b0;
        guard = 0;
        while (ready !== 1'b1 && guard < 20) begin
            guard++;
            step();
        end
        total++;
        if (accepts != 4 || exp_q.size() != 0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL hs_summary got accepts=%0d pending=%0d ready=%b need 4/0/1",
                     accepts, exp_q.size(), ready);
        end
    endtask

    task automatic count_leds(input int n, output int rc, output int gc, output int bc);
        rc = 0; gc = 0; bc = 0;
        for (int i = 0; i < n; i++) begin
            rc += int'(red);
            gc += int'(green);
            bc += int'(blue);
            step();
        end
    endtask

    task automatic test_pwm();
        int rc, gc, bc;
        logic [PWMB-1:0] duties[3];
        int need[3];
        duties[0] = 4'd0;  need[0] = 0;
        duties[1] = 4'd4;  need[1] = 8;
        duties[2] = 4'd15; need[2] = 30;
        duty = '1;
        do_compare(4'd3, 4'd3, 3'b010, "pwm_eq");
        for (int k = 0; k < 3; k++) begin
            duty = duties[k];
            step();
            step();
            count_leds(32, rc, gc, bc);
            total++;
            if (gc != need[k] || rc != 0 || bc != 0) begin
                bad++;
                $display("FAIL pwm_duty%0d got g=%0d r=%0d b=%0d need g=%0d r=0 b=0",
                         duties[k], gc, rc, bc, need[k]);
            end
        end
        duty = '1;
    endtask

    task automatic test_signed();
        int rc, gc, bc;
`ifdef RGB_CMP_SIGNED_EN
        do_compare(4'b1000, 4'b0001, 3'b001, "sign");
        count_leds(16, rc, gc, bc);
        total++;
        if (bc != 15 || rc != 0 || gc != 0) begin
            bad++;
            $display("FAIL sign_led got r=%0d g=%0d b=%0d need r=0 g=0 b=15", rc, gc, bc);
        end
`else
        do_compare(4'b1000, 4'b0001, 3'b100, "sign");
        count_leds(16, rc, gc, bc);
        total++;
        if (rc != 15 || gc != 0 || bc != 0) begin
            bad++;
            $display("FAIL sign_led got r=%0d g=%0d b=%0d need r=15 g=0 b=0", rc, gc, bc);
        end
`endif
    endtask

    task automatic test_mid_reset();
        a = 4'd1; b = 4'd2; valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        total++;
        if ({gt, eq, lt} !== 3'b001 || done !== 1'b1) begin
            bad++;
            $display("FAIL midrst_hold got flags=%b done=%b need 001/1", {gt, eq, lt}, done);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({gt, eq, lt, done} !== 4'b0 || ready !== 1'b1 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL midrst_cleared got flags=%b done=%b ready=%b state=%0d need 000/0/1/0",
                     {gt, eq, lt}, done, ready, dbg_state);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                bad++;
                $display("FAIL midrst_idle cycle=%0d got done=%b ready=%b need 0/1", i, done, ready);
            end
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; a = '0; b = '0; duty = '1;
        test_reset();
        test_exhaustive();
        test_handshake();
        test_pwm();
        test_signed();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
